pipo: RTL and testbench
=======================

PIPO -- requirements
Module: pipo

Interface
REQ-001 Parameter WIDTH, default 4: data width of the register in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 res  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-004 d  input  WIDTH  parallel data input.
REQ-005 load  input  1  load enable; active-high.
REQ-006 y  output  WIDTH  parallel data output, driven directly from the register.
REQ-007 Positional port order SHALL be d, res, clk, load, y.

Function
REQ-008 Block SHALL be a WIDTH-bit parallel-in/parallel-out register whose contents appear on y.
REQ-009 At a rising clk edge with res=1 and load=1, the register SHALL capture d, and y SHALL show the new value in the same cycle, after clock-to-q delay.
REQ-010 At a rising clk edge with res=1 and load=0, the register SHALL hold its value.
REQ-011 Changes on d while load=0 SHALL NOT affect y.
REQ-012 Changes on d or load between clock edges SHALL NOT affect y.
REQ-013 Load latency SHALL be one edge: the value of d sampled at edge N SHALL be visible on y after edge N.
REQ-014 Back-to-back loads on consecutive edges SHALL each capture the d present at that edge; no bubble cycle SHALL be inserted.
REQ-015 An X or Z value on load SHALL be treated as a hold, with no capture.
REQ-016 All bits SHALL load together; there SHALL be no partial or bit-wise enable.
REQ-017 y SHALL have no combinational path from d or load.

Reset
REQ-018 When res falls to 0, y SHALL go to all zeros immediately, without waiting for a clk edge.
REQ-019 While res=0, y SHALL stay all zeros regardless of clk, load and d.
REQ-020 Release of res (0->1) SHALL be synchronized to clk by the integrating logic; the block itself adds no reset synchronizer.
REQ-021 After release, the first capture SHALL occur at the first rising edge where res=1 and load=1.
REQ-022 If reset is asserted in the middle of a load cycle, reset SHALL win and y SHALL be 0.

Structure
REQ-023 A shared package pipo_pkg SHALL hold:
- the default-width constant PIPO_W = 4
- the reset-value constant PIPO_RST = '0
REQ-024 A single sub-module SHALL be used: pipo_bit, a 1-bit DFF with async active-low reset and a load-enable mux.
REQ-025 pipo_bit SHALL be instantiated WIDTH times from a generate loop.
REQ-026 The design SHALL contain no latches.
REQ-027 The design SHALL use only clk as a clock; there SHALL be no gated clocks.

Verification
REQ-028 Reset: start with res=0, d=4'b0000, load=0, then release res -> y=4'b0000 and it holds through 3 edges.
REQ-029 Load: d=4'b1001, load=1 for one edge, then load=0 -> y=4'b1001 after that edge and it holds while d changes to 4'b0110.
REQ-030 Reload: d=4'b1010, load=1 for one edge -> y changes from 4'b1001 to 4'b1010 at that edge.
REQ-031 Back-to-back: load=1 held while d=4'b0011 then 4'b1100 on consecutive edges -> y=0011, then y=1100.
REQ-032 Async reset mid-operation: with y=4'b1111, drop res between edges -> y=4'b0000 before the next edge; with load=1 and res=0 at an edge -> y stays 0000.
REQ-033 Hold: load=0 while d toggles at every half-period -> y never changes; the bench SHALL self-check y against a reference model at every edge.

Source files
------------

// File: rtl/pipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipo_pkg
// Brief    : Shared constants for the parallel-in/parallel-out register.
// Revision : 1.0 - initial release
// ============================================================================
package pipo_pkg;

  // Default register width
  localparam int PIPO_W = 4;

  // Widest register the block supports
  localparam int PIPO_MAX_W = 64;

  // Reset value; sliced per bit by the top, so it covers the widest register
  localparam logic [PIPO_MAX_W-1:0] PIPO_RST = '0;

endpackage : pipo_pkg
`default_nettype wire

// File: rtl/pipo_bit.sv
`default_nettype none
// ============================================================================
// Module   : pipo_bit
// Brief    : One register bit: DFF with async active-low reset and a
//            load-enable mux in front of D.
// Revision : 1.0 - initial release
// ============================================================================
module pipo_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic load,
  input  logic d,
  output logic q
);

  // Async clear, otherwise capture d only on an unambiguous load=1.
  // An unknown load fails the equality test and so holds the bit.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q <= RST_VAL;
    end else if (load == 1'b1) begin
      q <= d;
    end
  end

endmodule : pipo_bit
`default_nettype wire

// File: rtl/pipo.sv
`default_nettype none
// ============================================================================
// Module   : pipo
// Brief    : WIDTH-bit parallel-in/parallel-out register. y is driven
//            straight from the flops; all bits share one load enable.
//            Reset release must already be synchronous to clk.
// Revision : 1.0 - initial release
// ============================================================================
module pipo
  import pipo_pkg::*;
#(
  parameter int WIDTH = PIPO_W  // legal range 1..PIPO_MAX_W
) (
  input  logic [WIDTH-1:0] d,
  input  logic             res,
  input  logic             clk,
  input  logic             load,
  output logic [WIDTH-1:0] y
);

  // One flop per bit, all sharing clk, res and load so the word moves as a unit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipo_bit #(
      .RST_VAL (PIPO_RST[i])
    ) u_bit (
      .clk  (clk),
      .res  (res),
      .load (load),
      .d    (d[i]),
      .q    (y[i])
    );
  end

endmodule : pipo
`default_nettype wire

// File: tb/tb_pipo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipo
// Brief    : Directed scoreboard bench for pipo (WIDTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipo;

  localparam int W = 4;

  logic         clk;
  logic         res;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] y;

  logic [W-1:0] sb[$];
  logic [W-1:0] model;
  int           checks;
  int           errors;

  pipo #(.WIDTH(W)) dut (
    .d    (d),
    .res  (res),
    .clk  (clk),
    .load (load),
    .y    (y)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on run time
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Pop the oldest expectation and compare it with y
  task automatic check_out(input string tag);
    logic [W-1:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed %b expected <scoreboard empty>", tag, y);
    end else begin
      e = sb.pop_front();
      assert (y === e) else begin
        errors++;
        $error("FAIL %s observed %b expected %b", tag, y, e);
      end
    end
  endtask

  // Reference register update for one rising edge
  task automatic model_edge(input logic [W-1:0] din, input logic ld);
    if (res !== 1'b1)    model = '0;
    else if (ld === 1'b1) model = din;
  endtask

  // Drive d/load at the falling edge, predict, then check 1 time unit after the rising edge
  task automatic clk_step(input logic [W-1:0] din, input logic ld, input string tag);
    @(negedge clk);
    d    = din;
    load = ld;
    model_edge(din, ld);
    sb.push_back(model);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = '0;
    res    = 1'b0;
    d      = 4'b0000;
    load   = 1'b0;

    // Reset asserted from time zero: y must be zero before any edge
    #3;
    sb.push_back(4'b0000);
    check_out("rst_initial");

    // Reset held through edges even with load=1 and nonzero d
    clk_step(4'b1111, 1'b1, "rst_held_load");

    // Release reset away from the edge, then hold through 3 edges
    @(negedge clk);
    res  = 1'b1;
    load = 1'b0;
    clk_step(4'b0000, 1'b0, "rst_release_0");
    clk_step(4'b0000, 1'b0, "rst_release_1");
    clk_step(4'b0000, 1'b0, "rst_release_2");

    // Single load then hold while d changes
    clk_step(4'b1001, 1'b1, "load_1001");
    clk_step(4'b0110, 1'b0, "hold_after_load_a");
    clk_step(4'b0110, 1'b0, "hold_after_load_b");

    // Reload
    clk_step(4'b1010, 1'b1, "reload_1010");

    // Back-to-back loads, no bubble
    clk_step(4'b0011, 1'b1, "b2b_0011");
    clk_step(4'b1100, 1'b1, "b2b_1100");

    // Unknown load behaves as hold
    clk_step(4'b0101, 1'bx, "load_x_hold");
    clk_step(4'b0101, 1'b0, "hold_after_x");

    // Load all ones, then assert reset between edges
    clk_step(4'b1111, 1'b1, "load_1111");
    #2;
    res = 1'b0;
    model = '0;
    #1;
    sb.push_back(4'b0000);
    check_out("async_rst_mid");

    // Reset wins over load at an edge
    clk_step(4'b1111, 1'b1, "rst_wins_load");

    // Release and confirm first capture happens at the first loaded edge
    @(negedge clk);
    res  = 1'b1;
    load = 1'b0;
    clk_step(4'b1110, 1'b0, "post_rst_no_load");
    clk_step(4'b0110, 1'b1, "post_rst_first_load");

    // Hold with d toggling every half period, checked at every edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d    = ~d;
      load = 1'b0;
      model_edge(d, load);
      sb.push_back(model);
      @(posedge clk);
      #1;
      check_out("hold_toggle");
      #1;
      d = ~d;
    end

    // Final load of a distinct pattern after the hold run
    clk_step(4'b1011, 1'b1, "final_load");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipo
`default_nettype wire
